// File: rtl/dp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dp_pkg
// Description : Shared widths, element/vector types and sequencer states
//               for the dot_product_seq block.
// Revision    : 1.0 - initial release
// ============================================================================
package dp_pkg;

    localparam int LANES      = 8;
    localparam int ELEM_W     = 8;
    localparam int MAX_CHUNKS = 256;

    localparam int CNT_W  = $clog2(MAX_CHUNKS);
    localparam int PROD_W = 2 * ELEM_W;
    localparam int SUM_W  = PROD_W + $clog2(LANES);
    // One lane sum per chunk, so MAX_CHUNKS of them can never overflow this.
    localparam int ACC_W  = SUM_W + $clog2(MAX_CHUNKS);

    typedef logic [ELEM_W-1:0] elem_t;
    typedef elem_t [LANES-1:0] vec_t;
    typedef logic [PROD_W-1:0] prod_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dp_state_t;

endpackage : dp_pkg
`default_nettype wire

// File: rtl/dp_lane_sum.sv
`default_nettype none
// ============================================================================
// Module      : dp_lane_sum
// Description : Enable-gated registered stage: LANES multipliers summed into
//               one SUM_W result, with a valid bit that follows the enable.
// Revision    : 1.0 - initial release
// ============================================================================
module dp_lane_sum
    import dp_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [LANES*ELEM_W-1:0]   a,
    input  logic [LANES*ELEM_W-1:0]   b,
    output logic [SUM_W-1:0]          sum,
    output logic                      sum_valid
);

    vec_t             w_a;
    vec_t             w_b;
    prod_t            w_prod [LANES];
    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] r_sum;
    logic             r_sum_valid;

    assign w_a = a;
    assign w_b = b;

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            assign w_prod[i] = prod_t'(w_a[i]) * prod_t'(w_b[i]);
        end
    endgenerate

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_sum = w_sum + SUM_W'(w_prod[i]);
        end
    end

    // Valid follows the enable every cycle; the sum only moves on a new chunk.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sum       <= '0;
            r_sum_valid <= 1'b0;
        end else begin
            r_sum_valid <= en;
            if (en) begin
                r_sum <= w_sum;
            end
        end
    end

    assign sum       = r_sum;
    assign sum_valid = r_sum_valid;

endmodule : dp_lane_sum
`default_nettype wire

// File: rtl/dot_product_seq.sv
`default_nettype none
// ============================================================================
// Module      : dot_product_seq
// Description : Job sequencer for long-vector dot products: takes a chunk
//               count, streams chunks through dp_lane_sum, returns one sum.
// Revision    : 1.0 - initial release
// ============================================================================
module dot_product_seq
    import dp_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [CNT_W-1:0]          cmd_len,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*ELEM_W-1:0]   in_a,
    input  logic [LANES*ELEM_W-1:0]   in_b,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [ACC_W-1:0]          res_data,
    output logic                      busy
);

    dp_state_t        r_state;
    dp_state_t        w_next_state;
    logic [CNT_W-1:0] r_remaining;
    logic [ACC_W-1:0] r_acc;
    logic             r_res_valid;
    logic [ACC_W-1:0] r_res_data;
    logic [SUM_W-1:0] w_stage_sum;
    logic             w_stage_valid;
    logic             w_cmd_fire;
    logic             w_in_fire;

    assign w_cmd_fire = cmd_valid && cmd_ready;
    assign w_in_fire  = in_valid && in_ready;

    dp_lane_sum u_lane_sum (
        .clk       (clk),
        .reset     (reset),
        .en        (w_in_fire),
        .a         (in_a),
        .b         (in_b),
        .sum       (w_stage_sum),
        .sum_valid (w_stage_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        cmd_ready    = 1'b0;
        in_ready     = 1'b0;
        busy         = 1'b1;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    w_next_state = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && (r_remaining == '0)) begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: begin
                w_next_state = DONE;
            end
            DONE: begin
                if (r_res_valid && res_ready) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // DONE spends its first cycle capturing the final accumulator into the
    // result register, so res_data is stable for as long as res_valid is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_remaining <= '0;
            r_acc       <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
        end else begin
            if (w_cmd_fire) begin
                r_remaining <= cmd_len;
            end else if (w_in_fire && (r_remaining != '0)) begin
                r_remaining <= r_remaining - CNT_W'(1);
            end

            if (w_cmd_fire) begin
                r_acc <= '0;
            end else if (w_stage_valid) begin
                r_acc <= r_acc + ACC_W'(w_stage_sum);
            end

            if (r_state == DONE) begin
                if (!r_res_valid) begin
                    r_res_valid <= 1'b1;
                    r_res_data  <= r_acc;
                end else if (res_ready) begin
                    r_res_valid <= 1'b0;
                end
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;

endmodule : dot_product_seq
`default_nettype wire
